if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port stall  input  6  pipeline stall vector from ctrl; bit0 = PC, bit1 = IF, 1 = Stop.
REQ-005 SHALL have port branch_flag_i  input  1  one-cycle redirect pulse from ID.
REQ-006 SHALL have port branch_target_i  input  32  redirect address, valid with branch_flag_i.
REQ-007 SHALL have port ibus_req_o  output  1  instruction bus request.
REQ-008 SHALL have port ibus_addr_o  output  32  word address of request.
REQ-009 SHALL have port ibus_ack_i  input  1  one-cycle completion strobe.
REQ-010 SHALL have port ibus_data_i  input  32  fetched word, valid with ibus_ack_i.
REQ-011 SHALL have port pc_o  output  32  PC of presented instruction, to IF/ID register.
REQ-012 SHALL have port inst_o  output  32  presented instruction, to IF/ID register.
REQ-013 SHALL have port stallreq_o  output  1  stall request to ctrl.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; internal regs pc, inst_buf, redir_pend, redir_pc.
REQ-015 IDLE: SHALL, when stall[0]=0, assert ibus_req_o with ibus_addr_o=pc next cycle and enter BUSY; else stay IDLE.
REQ-016 BUSY: SHALL hold ibus_req_o=1 and ibus_addr_o stable until ibus_ack_i; never abandon a request.
REQ-017 BUSY + ack + no redirect pending/arriving: SHALL latch ibus_data_i into inst_buf, drop ibus_req_o, enter DONE.
REQ-018 DONE: SHALL drive pc_o=pc, inst_o=inst_buf, stallreq_o=0.
REQ-019 DONE + stall[1]=0 at edge: SHALL set pc<=pc+4 (mod 2^32), assert request for pc+4, enter BUSY (back-to-back fetch, no bubble).
REQ-020 DONE + stall[1]=1: SHALL hold pc, inst_buf and state unchanged.
REQ-021 Outside DONE: SHALL drive inst_o=32'h0 (nop), pc_o=pc, stallreq_o=1.
REQ-022 branch_flag_i in IDLE or DONE: SHALL set pc<=branch_target_i, drop presented instruction, enter IDLE; takes priority over REQ-019.
REQ-023 branch_flag_i in BUSY without ack: SHALL set redir_pend=1, redir_pc=branch_target_i; request continues.
REQ-024 BUSY + ack with redir_pend=1 or branch_flag_i same cycle: SHALL discard ibus_data_i, set pc<=redirect target (branch_flag_i wins over redir_pc), clear redir_pend, enter IDLE.
REQ-025 Second branch_flag_i while redir_pend=1: SHALL overwrite redir_pc.
REQ-026 branch_target_i bits[1:0] SHALL be ignored (forced 0).
REQ-027 Latency: ack to valid inst_o SHALL be 1 cycle; branch to first redirected request SHALL be 2 cycles from IDLE/DONE.

Reset
REQ-028 rst=1 at edge SHALL set pc=RESET_PC, state=IDLE, ibus_req_o=0, ibus_addr_o=0, inst_buf=0, redir_pend=0, redir_pc=0.
REQ-029 During reset outputs SHALL be pc_o=RESET_PC, inst_o=0, stallreq_o=1.
REQ-030 rst asserted in BUSY SHALL drop request immediately; an ack arriving afterward SHALL be ignored.

Structure
REQ-031 Shared defines SHALL hold RstEnable, Stop/NoStop, ZeroWord, InstAddrBus, InstBus and FSM state encodings.
REQ-032 RESET_PC default SHALL reside in the shared defines; module parameter overrides.
REQ-033 No sub-module; single always block for state/regs plus combinational output logic.

Verification
REQ-034 Reset then ack after 2 cycles with data 32'h00000013 -> ibus_addr_o=32'h80000000, then pc_o=32'h80000000, inst_o=32'h00000013, stallreq_o=0.
REQ-035 Zero-wait acks, stall=0 -> addresses 0x80000000, 0x80000004, 0x80000008 on consecutive requests, no idle cycle.
REQ-036 DONE with stall[1]=1 for 3 cycles -> pc_o/inst_o constant, no new request; release -> request 0x80000004.
REQ-037 Branch to 32'h80001000 during BUSY, ack 2 cycles later with 32'hDEADBEEF -> data discarded, inst_o=0, next request address 0x80001000.
REQ-038 Branch to 32'h80002002 coincident with ack -> data discarded, next request 0x80002000.
REQ-039 rst mid-BUSY, late ack -> ibus_req_o=0 next cycle, ack ignored, next request 0x80000000.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: control polarities,
// bus widths, reset fetch address and fetch FSM state encodings.
package if_stage_pkg;

   localparam logic RstEnable  = 1'b1;
   localparam logic Stop       = 1'b1;
   localparam logic NoStop     = 1'b0;

   localparam int InstAddrBus  = 32;
   localparam int InstBus      = 32;

   localparam logic [31:0] ZeroWord         = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

   localparam logic [1:0] FETCH_IDLE = 2'd0;
   localparam logic [1:0] FETCH_BUSY = 2'd1;
   localparam logic [1:0] FETCH_DONE = 2'd2;

   // Redirect targets are always word aligned; low two bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one word fetch at a time on the
// instruction bus, presents the fetched word to IF/ID, and handles
// redirects that arrive before, during or after a fetch.
//
// state      | meaning
// -----------+------------------------------------------------------------
// FETCH_IDLE | no request outstanding; pc holds the next fetch address
// FETCH_BUSY | request for pc outstanding, waiting for ibus_ack_i
// FETCH_DONE | fetched word in inst_buf is presented on inst_o
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [InstAddrBus-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [5:0]             stall,
   input  logic                   branch_flag_i,
   input  logic [InstAddrBus-1:0] branch_target_i,
   output logic                   ibus_req_o,
   output logic [InstAddrBus-1:0] ibus_addr_o,
   input  logic                   ibus_ack_i,
   input  logic [InstBus-1:0]     ibus_data_i,
   output logic [InstAddrBus-1:0] pc_o,
   output logic [InstBus-1:0]     inst_o,
   output logic                   stallreq_o
);

   logic [1:0]             state;
   logic [InstAddrBus-1:0] pc;
   logic [InstBus-1:0]     inst_buf;
   logic                   redir_pend;
   logic [InstAddrBus-1:0] redir_pc;
   logic                   req_q;
   logic [InstAddrBus-1:0] addr_q;
   logic [InstAddrBus-1:0] br_target;
   logic                   in_reset;
   logic                   stall_unused;

   // Only the PC and IF stall bits matter to this stage.
   assign stall_unused = ^stall[5:2];

   assign br_target = word_align(branch_target_i);
   assign in_reset  = (rst == RstEnable);

   // Fetch FSM and all stage registers; a request, once issued, is only
   // retired by its ack (or by reset), so redirects during a fetch are
   // parked in redir_pend/redir_pc and applied when the ack arrives.
   always_ff @(posedge clk) begin
      if (in_reset) begin
         state      <= FETCH_IDLE;
         pc         <= RESET_PC;
         inst_buf   <= ZeroWord;
         redir_pend <= 1'b0;
         redir_pc   <= ZeroWord;
         req_q      <= 1'b0;
         addr_q     <= ZeroWord;
      end else begin
         case (state)
            FETCH_IDLE: begin
               if (branch_flag_i) begin
                  pc <= br_target;
               end else if (stall[0] == NoStop) begin
                  req_q  <= 1'b1;
                  addr_q <= pc;
                  state  <= FETCH_BUSY;
               end
            end
            FETCH_BUSY: begin
               if (ibus_ack_i) begin
                  req_q      <= 1'b0;
                  redir_pend <= 1'b0;
                  if (branch_flag_i) begin
                     // a redirect arriving with the ack beats a parked one
                     pc    <= br_target;
                     state <= FETCH_IDLE;
                  end else if (redir_pend) begin
                     pc    <= redir_pc;
                     state <= FETCH_IDLE;
                  end else begin
                     inst_buf <= ibus_data_i;
                     state    <= FETCH_DONE;
                  end
               end else if (branch_flag_i) begin
                  redir_pend <= 1'b1;
                  redir_pc   <= br_target;
               end
            end
            FETCH_DONE: begin
               if (branch_flag_i) begin
                  pc    <= br_target;
                  state <= FETCH_IDLE;
               end else if (stall[1] == NoStop) begin
                  // next fetch issues on the same edge the word is consumed
                  pc     <= pc + 32'd4;
                  req_q  <= 1'b1;
                  addr_q <= pc + 32'd4;
                  state  <= FETCH_BUSY;
               end
            end
            default: begin
               req_q <= 1'b0;
               state <= FETCH_IDLE;
            end
         endcase
      end
   end

   // Stage outputs; reset masks the request and forces the reset view
   // immediately rather than waiting for the edge.
   always_comb begin
      ibus_req_o  = req_q & ~in_reset;
      ibus_addr_o = addr_q;
      pc_o        = in_reset ? RESET_PC : pc;
      if (!in_reset && state == FETCH_DONE) begin
         inst_o     = inst_buf;
         stallreq_o = NoStop;
      end else begin
         inst_o     = ZeroWord;
         stallreq_o = Stop;
      end
   end

endmodule
